// File: rtl/sort_param.sv
// Parametrised bubble sorter: one compare-and-swap per clock, runtime sort
// direction, early exit on a swap-free pass, and a count of passes executed.
module sort_param #(
  parameter int unsigned N   = 32,
  parameter int unsigned W   = 7,
  parameter int unsigned PCW = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic             descending,
  input  logic [N*W-1:0]   data_in,
  output logic [N*W-1:0]   data_out,
  output logic             busy,
  output logic             done,
  output logic [PCW-1:0]   pass_count
);

  localparam int unsigned IW = $clog2(N);

  if (N < 2) begin : g_bad_n
    $error("sort_param: N must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t           state_q;
  logic [W-1:0]     arr_q [N];
  logic [W-1:0]     arr_d [N];
  logic [IW-1:0]    idx_q, idx_nxt, bound_q;
  logic             swapped_q, mode_q;
  logic [PCW-1:0]   pcnt_q, pcnt_inc, pass_count_q;
  logic [N*W-1:0]   data_out_q, sorted_flat;
  logic [W-1:0]     elem_a, elem_b;
  logic             out_of_order, end_pass, last_pass;

  always_comb begin
    idx_nxt      = idx_q + 1'b1;
    elem_a       = arr_q[idx_q];
    elem_b       = arr_q[idx_nxt];
    out_of_order = mode_q ? (elem_a < elem_b) : (elem_a > elem_b);
    end_pass     = (idx_nxt == bound_q);
    // A pass is final if nothing moved, counting the swap made this very cycle.
    last_pass    = (bound_q == IW'(1)) || !(swapped_q || out_of_order);
    pcnt_inc     = pcnt_q + 1'b1;
    arr_d        = arr_q;
    if (out_of_order) begin
      arr_d[idx_q]   = elem_b;
      arr_d[idx_nxt] = elem_a;
    end
    sorted_flat = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sorted_flat[k*W +: W] = arr_d[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      bound_q      <= '0;
      swapped_q    <= 1'b0;
      mode_q       <= 1'b0;
      pcnt_q       <= '0;
      pass_count_q <= '0;
      data_out_q   <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        arr_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int unsigned k = 0; k < N; k++) begin
              arr_q[k] <= data_in[k*W +: W];
            end
            mode_q    <= descending;
            idx_q     <= '0;
            bound_q   <= IW'(N - 1);
            swapped_q <= 1'b0;
            pcnt_q    <= '0;
            state_q   <= SORT;
          end
        end
        SORT: begin
          arr_q <= arr_d;
          if (end_pass) begin
            pcnt_q <= pcnt_inc;
            if (last_pass) begin
              data_out_q   <= sorted_flat;
              pass_count_q <= pcnt_inc;
              state_q      <= DONE;
            end else begin
              bound_q   <= bound_q - 1'b1;
              idx_q     <= '0;
              swapped_q <= 1'b0;
            end
          end else begin
            idx_q     <= idx_nxt;
            swapped_q <= swapped_q || out_of_order;
          end
        end
        DONE: begin
          if (ack) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q == SORT);
  assign done       = (state_q == DONE);
  assign data_out   = data_out_q;
  assign pass_count = pass_count_q;

endmodule

// File: tb/tb_sort_param.sv
// Bench for sort_param (N=8, W=8): directed scenarios plus randomized sorts,
// all outputs compared each cycle against a value-level sorting model.
module tb_sort_param;

  localparam int NN = 8;
  localparam int WW = 8;
  localparam int PW = $clog2(NN) + 1;

  typedef int unsigned arr8_t [NN];

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              ack = 1'b0;
  logic              descending = 1'b0;
  logic [NN*WW-1:0]  data_in = '0;
  logic [NN*WW-1:0]  data_out;
  logic              busy, done;
  logic [PW-1:0]     pass_count;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  sort_param #(.N(NN), .W(WW)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .descending(descending), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk8(input arr8_t e);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < NN; k++) r[k*WW +: WW] = e[k][WW-1:0];
    return r;
  endfunction

  // Bubble sort needs as many swapping passes as the largest number of
  // out-of-order elements preceding any element, plus one clean pass unless
  // the shrinking bound already reached 1.
  function automatic void model_sort(input logic [63:0] din, input logic desc,
                                     output logic [63:0] res, output int passes,
                                     output int cycles);
    int unsigned v [NN];
    int m, c, j;
    int unsigned t;
    for (int k = 0; k < NN; k++) v[k] = din[k*WW +: WW];
    m = 0;
    for (int k = 0; k < NN; k++) begin
      c = 0;
      for (int i = 0; i < k; i++)
        if (desc ? (v[i] < v[k]) : (v[i] > v[k])) c++;
      if (c > m) m = c;
    end
    passes = (m + 1 < NN - 1) ? m + 1 : NN - 1;
    cycles = 0;
    for (int p = 1; p <= passes; p++) cycles += NN - p;
    for (int k = 1; k < NN; k++) begin
      t = v[k];
      j = k;
      while (j > 0 && (desc ? (v[j-1] < t) : (v[j-1] > t))) begin
        v[j] = v[j-1];
        j--;
      end
      v[j] = t;
    end
    res = '0;
    for (int k = 0; k < NN; k++) res[k*WW +: WW] = v[k][WW-1:0];
  endfunction

  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_pc_pend = 0;
  logic [63:0] m_res_pend = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [63:0] exp_data = '0;
  logic [PW-1:0] exp_pc = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  = 0;
      exp_data = '0;
      exp_pc   = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
             model_sort(data_in, descending, m_res_pend, m_pc_pend, m_cnt);
             m_phase = 1;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) begin
               m_phase  = 2;
               exp_data = m_res_pend;
               exp_pc   = m_pc_pend[PW-1:0];
             end
           end
        default: if (ack) m_phase = 0;
      endcase
    end
    exp_busy = (m_phase == 1);
    exp_done = (m_phase == 2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("data_out", data_out, exp_data);
      check("pass_count", pass_count, exp_pc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] d, input logic desc);
    data_in = d;
    descending = desc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      step();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d cycles required=done", cyc);
    end
  endtask

  task automatic release_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [63:0] d;
    int mx;

    step(2);
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", data_out, 64'd0);
    check("rst_pc", pass_count, 4'd0);
    reset = 1'b0;
    step(10);
    check("idle_data", data_out, 64'd0);
    check("idle_busy", busy, 1'b0);

    // Reverse ascending: worst case
    do_start(pk8('{7, 6, 5, 4, 3, 2, 1, 0}), 1'b0);
    check("busy_rise", busy, 1'b1);
    wait_done(cyc);
    check("rev_latency", cyc, 28);
    check("rev_data", data_out, pk8('{0, 1, 2, 3, 4, 5, 6, 7}));
    check("rev_pc", pass_count, 4'd7);
    step(20);
    check("hold_done", done, 1'b1);
    check("hold_data", data_out, pk8('{0, 1, 2, 3, 4, 5, 6, 7}));
    release_ack();
    check("ack_idle", done, 1'b0);

    // Already sorted: early exit after one pass
    do_start(pk8('{1, 2, 3, 4, 5, 6, 7, 8}), 1'b0);
    wait_done(cyc);
    check("sorted_latency", cyc, 7);
    check("sorted_pc", pass_count, 4'd1);
    check("sorted_data", data_out, pk8('{1, 2, 3, 4, 5, 6, 7, 8}));
    release_ack();

    // Descending with duplicates, mode toggled and start pulsed mid-sort
    do_start(pk8('{3, 9, 3, 0, 255, 9, 1, 0}), 1'b1);
    step(3);
    descending = 1'b0;
    step(2);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc);
    check("desc_data", data_out, pk8('{255, 9, 9, 3, 3, 1, 0, 0}));
    data_in = pk8('{4, 4, 1, 8, 0, 2, 2, 6});
    ack = 1'b1;
    start = 1'b1;
    step();
    ack = 1'b0;
    start = 1'b0;
    step(3);
    check("no_new_sort_busy", busy, 1'b0);
    check("no_new_sort_done", done, 1'b0);
    do_start(data_in, 1'b0);
    wait_done(cyc);
    check("second_data", data_out, pk8('{0, 1, 2, 2, 4, 4, 6, 8}));
    release_ack();

    // Reset mid-sort
    do_start(pk8('{7, 6, 5, 4, 3, 2, 1, 0}), 1'b0);
    step(5);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_data", data_out, 64'd0);
    check("mid_rst_pc", pass_count, 4'd0);
    step(2);
    reset = 1'b0;
    step();
    do_start(pk8('{2, 1, 0, 0, 0, 0, 0, 0}), 1'b0);
    wait_done(cyc);
    check("post_rst_data", data_out, pk8('{0, 0, 0, 0, 0, 0, 1, 2}));
    release_ack();

    // Randomized sorts with disturbances on start/descending/data_in
    for (int it = 0; it < 25; it++) begin
      mx = ($urandom_range(0, 1) == 1) ? 3 : 255;
      for (int k = 0; k < NN; k++) d[k*WW +: WW] = WW'($urandom_range(0, mx));
      do_start(d, 1'($urandom_range(0, 1)));
      cyc = 0;
      while (!done && cyc < 400) begin
        start = ($urandom_range(0, 3) == 0);
        descending = 1'($urandom_range(0, 1));
        data_in = {$urandom, $urandom};
        step();
        cyc++;
      end
      start = 1'b0;
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout actual=%0d cycles required=done", cyc);
      end
      step($urandom_range(0, 5));
      ack = 1'b1;
      start = 1'($urandom_range(0, 1));
      step();
      ack = 1'b0;
      start = 1'b0;
      step();
    end

    step(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
